// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Holds the FSM encoding and counter sizing helpers.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Counter width for an arbitrary operand width (legal widths are >= 2).
  function automatic int cnt_w(input int w);
    if (w < 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_seq_fa.sv
// One-bit full-adder slice fed by the serial sequencer.
// Purely combinational; carry is held by the caller.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: feeds operands LSB-first into a one-bit slice,
// rebuilds the sum MSB-inward and pulses done for one cycle.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             x_bit,
  output logic             y_bit
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic in_shift;
  logic fa_s;
  logic fa_c;

  assign in_shift = (state_q == SHIFT);
  assign x_bit    = in_shift & ra_q[0];
  assign y_bit    = in_shift & rb_q[0];

  full_adder_bit u_fa (
    .x    (x_bit),
    .y    (y_bit),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          ps_d    = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ps_d = {fa_s, ps_q[WIDTH-1:1]};
        ra_d = ra_q >> 1;
        rb_d = rb_q >> 1;
        c_d  = fa_c;
        // Counter parks on the last index so it never wraps.
        if (cnt_q == LAST) begin
          sum_d   = ps_d;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed + random bench for serial_adder_seq at WIDTH=8.
// Expected results come from plain integer addition.
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         x_bit;
  logic         y_bit;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int prev_e0  = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .x_bit (x_bit),
    .y_bit (y_bit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    int t;
    t = int'(x) + int'(y);
    return t[W:0];
  endfunction

  // hold: keep start high throughout; inject: pulse start mid-shift;
  // tp: check distance from previous accepted start equals W+2.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold, input bit inject, input bit tp);
    logic [W:0] exp;
    exp   = model(av, bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    if (tp) chk("throughput", cyc - prev_e0, W + 2);
    prev_e0 = cyc;
    if (!hold) start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("x_bit", x_bit, (av >> i) & 1);
      chk("y_bit", y_bit, (bv >> i) & 1);
      chk("busy_shift", busy, 1);
      chk("done_early", done, 0);
      if (inject && i == 3) begin
        start = 1'b1;
        a     = ~av;
        b     = ~bv;
      end
      tick();
      if (inject && i == 3 && !hold) start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    chk("x_idle", x_bit, 0);
    tick();
    chk("done_single", done, 0);
    chk("busy_after", busy, 0);
    chk("sum_hold", sum, exp[W-1:0]);
    chk("cout_hold", cout, exp[W]);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_x", x_bit, 0);
    chk("rst_y", y_bit, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    run_add(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);

    // Back-to-back as early as allowed.
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_add(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    start = 1'b0;

    // Start held continuously.
    run_add(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    run_add(8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
    run_add(8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    tick();

    // Start while busy is ignored.
    run_add(8'h5C, 8'hA7, 1'b0, 1'b1, 1'b0);
    tick();
    chk("no_extra_done", done, 0);
    chk("no_extra_busy", busy, 0);

    // Reset during the 4th SHIFT cycle.
    a     = 8'h0F;
    b     = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_x", x_bit, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", busy, 0);
    run_add(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_add(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
      if ($urandom_range(1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
